// File: rtl/pwm_motor_ctrl.sv
// Multi-channel PWM motor controller with per-channel duty ramping and safe direction reversal.
// All channels share one period counter, so every PWM edge stays in phase.
module pwm_motor_ctrl #(
   parameter int unsigned CH        = 2,
   parameter int unsigned CW        = 16,
   parameter int unsigned PERIOD    = 55555,
   parameter int unsigned DW        = 8,
   parameter int unsigned DUTY_MAX  = 100,
   parameter int unsigned RAMP_STEP = 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [CH-1:0]    en,
   input  logic [CH-1:0]    dir,
   input  logic [CH*DW-1:0] duty,
   output logic [CH-1:0]    pwm_out,
   output logic [CH-1:0]    dir_out,
   output logic [CH-1:0]    motor_en,
   output logic [CH-1:0]    at_target,
   output logic             period_tick
);

   localparam int unsigned STEP   = PERIOD / DUTY_MAX;
   localparam int unsigned RS_CL  = (RAMP_STEP > DUTY_MAX) ? DUTY_MAX : RAMP_STEP;
   localparam logic [CW-1:0] LAST   = CW'(PERIOD - 1);
   localparam logic [CW-1:0] STEP_W = CW'(STEP);
   localparam logic [DW-1:0] DMAX   = DW'(DUTY_MAX);
   localparam logic [DW-1:0] RS     = DW'(RS_CL);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_REV} state_e;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;
   logic          boundary_c;
   state_e        state_q [CH];
   state_e        state_d [CH];
   logic [DW-1:0] cur_q [CH];
   logic [DW-1:0] cur_d [CH];
   logic [DW-1:0] tgt_q [CH];
   logic [DW-1:0] tgt_d [CH];
   logic [CH-1:0] dir_q, dir_d, pwm_q, pwm_d, men_q, men_d, att_q, att_d;
   logic [DW-1:0] duty_c, clamp_c;
   logic [CW-1:0] cmp_c;

   // Step cur toward tgt by at most RS; the step is capped by the distance, so no overshoot.
   function automatic logic [DW-1:0] ramp_to(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
      logic [DW-1:0] diff;
      if (cur < tgt) begin
         diff    = tgt - cur;
         ramp_to = cur + ((diff < RS) ? diff : RS);
      end else begin
         diff    = cur - tgt;
         ramp_to = cur - ((diff < RS) ? diff : RS);
      end
   endfunction

   always_comb begin
      boundary_c = (cnt_q == LAST);
      cnt_d      = boundary_c ? '0 : cnt_q + CW'(1);
   end

   // Per-channel state machine; en low overrides everything, duty only matters at boundaries.
   always_comb begin
      dir_d   = dir_q;
      pwm_d   = '0;
      duty_c  = '0;
      clamp_c = '0;
      cmp_c   = '0;
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         cur_d[i]   = cur_q[i];
         duty_c     = duty[i*DW +: DW];
         clamp_c    = (duty_c > DMAX) ? DMAX : duty_c;
         tgt_d[i]   = boundary_c ? clamp_c : tgt_q[i];
         if (!en[i]) begin
            state_d[i] = S_OFF;
            cur_d[i]   = '0;
         end else begin
            case (state_q[i])
               S_OFF: begin
                  dir_d[i]   = dir[i];
                  state_d[i] = S_RUN;
               end
               S_RUN: begin
                  if (dir[i] != dir_q[i]) state_d[i] = S_REV;
                  else if (boundary_c)    cur_d[i]   = ramp_to(cur_q[i], clamp_c);
               end
               S_REV: begin
                  if (boundary_c) begin
                     if (cur_q[i] == '0) begin
                        dir_d[i]   = dir[i];
                        state_d[i] = S_RUN;
                     end else begin
                        cur_d[i] = ramp_to(cur_q[i], '0);
                     end
                  end
               end
               default: state_d[i] = S_OFF;
            endcase
         end
         // DUTY_MAX*STEP <= PERIOD < 2^CW, so the product fits in CW bits.
         cmp_c    = CW'(cur_q[i]) * STEP_W;
         pwm_d[i] = en[i] && (state_q[i] != S_OFF) && (cnt_q < cmp_c);
      end
   end

   always_comb begin
      men_d = '0;
      att_d = '0;
      for (int i = 0; i < CH; i++) begin
         men_d[i] = (state_d[i] != S_OFF);
         att_d[i] = (state_d[i] == S_RUN) && (cur_d[i] == tgt_d[i]);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         dir_q  <= '0;
         pwm_q  <= '0;
         men_q  <= '0;
         att_q  <= '0;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= S_OFF;
            cur_q[i]   <= '0;
            tgt_q[i]   <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= boundary_c;
         dir_q  <= dir_d;
         pwm_q  <= pwm_d;
         men_q  <= men_d;
         att_q  <= att_d;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            cur_q[i]   <= cur_d[i];
            tgt_q[i]   <= tgt_d[i];
         end
      end
   end

   assign pwm_out     = pwm_q;
   assign dir_out     = dir_q;
   assign motor_en    = men_q;
   assign at_target   = att_q;
   assign period_tick = tick_q;

endmodule
